// File: rtl/pixel_write_queue_pkg.sv
// Shared screen geometry, request record and state encoding for the pixel write queue.
// Also provides the frame-buffer address helper used by the drain side.
package pixel_write_queue_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int FB_AW    = 17;
  localparam int COLOR_W  = 12;
  localparam int XW       = 9;
  localparam int YW       = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROM   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  typedef struct packed {
    logic [XW-1:0]      x;
    logic [YW-1:0]      y;
    logic [COLOR_W-1:0] c;
    logic               bg;
  } pixel_req_t;

  localparam int REQ_W = $bits(pixel_req_t);

  // y*320 + x without a multiplier; the largest result (76799) fits in 17 bits.
  function automatic logic [FB_AW-1:0] fb_addr_of(input logic [XW-1:0] x,
                                                   input logic [YW-1:0] y);
    logic [FB_AW-1:0] yw;
    yw = FB_AW'(y);
    return (yw << 8) + (yw << 6) + FB_AW'(x);
  endfunction

endpackage

// File: rtl/pixel_write_queue_if.sv
// Plot-request, background-ROM and frame-buffer signals of the pixel write queue.
// The queue itself uses the slave view; whoever drives requests and models the memories uses master.
interface pixel_write_queue_if;
  import pixel_write_queue_pkg::*;

  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic [COLOR_W-1:0] c;
  logic               bg;
  logic               plot;
  logic               plot_ready;
  logic [FB_AW-1:0]   rom_addr;
  logic [COLOR_W-1:0] rom_data;
  logic [FB_AW-1:0]   fb_addr;
  logic [COLOR_W-1:0] fb_data;
  logic               fb_we;
  logic               fb_busy;
  logic               idle;
  logic               overflow;

  modport slave (
    input  x, y, c, bg, plot, rom_data, fb_busy,
    output plot_ready, rom_addr, fb_addr, fb_data, fb_we, idle, overflow
  );

  modport master (
    output x, y, c, bg, plot, rom_data, fb_busy,
    input  plot_ready, rom_addr, fb_addr, fb_data, fb_we, idle, overflow
  );

endinterface

// File: rtl/pixel_write_queue_fifo.sv
// Synchronous FIFO holding accepted plot requests; the head entry is read straight from
// flop storage so the drain FSM can act on it in the same cycle it pops.
module plot_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 30
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign count   = cnt;
  assign dout    = mem[rd_ptr];

  // NOTE: state updates use <= so every flop samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pixel_write_queue.sv
// Buffers plot requests and drains them into the 320x240 frame buffer, substituting the
// background ROM pixel for bg requests so erased sprites restore the board image.
module pixel_write_queue
  import pixel_write_queue_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int ROM_LAT = 2
) (
  input logic               clk,
  input logic               reset,
  pixel_write_queue_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int LAT_W = $clog2(ROM_LAT + 1);

  state_t             state;
  logic [LAT_W-1:0]   rom_cnt;
  logic               fb_we_q;
  logic [FB_AW-1:0]   fb_addr_q;
  logic [COLOR_W-1:0] fb_data_q;
  logic [FB_AW-1:0]   rom_addr_q;
  logic               overflow_q;

  pixel_req_t         in_req;
  pixel_req_t         head;
  logic [REQ_W-1:0]   head_bits;
  logic [FB_AW-1:0]   head_addr;
  logic               in_range;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [CNT_W-1:0]   count;

  assign in_req    = '{x: bus.x, y: bus.y, c: bus.c, bg: bus.bg};
  assign in_range  = (bus.x < XW'(SCREEN_W)) && (bus.y < YW'(SCREEN_H));
  assign push      = bus.plot && in_range;
  assign head      = pixel_req_t'(head_bits);
  assign head_addr = fb_addr_of(head.x, head.y);

  // A new entry may leave the FIFO only when no write is pending or the pending one completes now.
  assign pop = !empty && ((state == S_IDLE) || (state == S_WRITE && !bus.fb_busy));

  plot_fifo #(
    .DEPTH (DEPTH),
    .W     (REQ_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (in_req),
    .pop   (pop),
    .dout  (head_bits),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      rom_cnt    <= '0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
      rom_addr_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (bus.plot && full) overflow_q <= 1'b1;

      if (pop) begin
        if (head.bg) begin
          state      <= S_ROM;
          fb_we_q    <= 1'b0;
          rom_addr_q <= head_addr;
          rom_cnt    <= LAT_W'(ROM_LAT);
        end else begin
          state     <= S_WRITE;
          fb_we_q   <= 1'b1;
          fb_addr_q <= head_addr;
          fb_data_q <= head.c;
        end
      end else begin
        unique case (state)
          S_IDLE: ;
          S_ROM: begin
            if (rom_cnt == '0) begin
              state     <= S_WRITE;
              fb_we_q   <= 1'b1;
              fb_addr_q <= rom_addr_q;
              fb_data_q <= bus.rom_data;
            end else begin
              rom_cnt <= rom_cnt - 1'b1;
            end
          end
          S_WRITE: begin
            if (!bus.fb_busy) begin
              state   <= S_IDLE;
              fb_we_q <= 1'b0;
            end
          end
          default: begin
            state   <= S_IDLE;
            fb_we_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.plot_ready = (count != CNT_W'(DEPTH));
  assign bus.idle       = (count == '0) && (state == S_IDLE);
  assign bus.fb_we      = fb_we_q;
  assign bus.fb_addr    = fb_addr_q;
  assign bus.fb_data    = fb_data_q;
  assign bus.rom_addr   = rom_addr_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_pixel_write_queue.sv
// Randomised scoreboard bench for pixel_write_queue: stimulus pushes the expected frame-buffer
// writes (address y*320+x, colour or ROM pixel) and a monitor pops them as writes complete.
module tb_pixel_write_queue;
  import pixel_write_queue_pkg::*;

  localparam int DEPTH   = 8;
  localparam int ROM_LAT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pixel_write_queue_if bus();

  pixel_write_queue #(
    .DEPTH   (DEPTH),
    .ROM_LAT (ROM_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [16:0] addr;
    logic [11:0] data;
  } wr_t;

  int  tests_run = 0;
  int  failed    = 0;
  int  writes    = 0;
  bit  ovf_exp   = 1'b0;
  bit  busy_force = 1'b0;
  bit  busy_rand  = 1'b0;
  wr_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Background image: arbitrary but deterministic, with the corner pixel fixed.
  function automatic logic [11:0] rom_fn(input int a);
    if (a == 76799) return 12'h0A5;
    return 12'(a * 37 + a / 3);
  endfunction

  logic [11:0] rom_pipe [ROM_LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_fn(int'(bus.rom_addr));
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign bus.rom_data = rom_pipe[ROM_LAT-1];

  initial begin
    bus.fb_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.fb_busy = busy_force || (busy_rand && ($urandom_range(0, 1) == 1));
    end
  end

  // Monitor: every completed write must match the oldest outstanding expectation,
  // and a stalled write must hold its address and data.
  initial begin
    bit          stall;
    logic [16:0] pa;
    logic [11:0] pd;
    wr_t         e;
    stall = 1'b0;
    pa    = '0;
    pd    = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall = 1'b0;
        continue;
      end
      if (stall) begin
        check("hold_we", bus.fb_we, 1);
        check("hold_addr", bus.fb_addr, pa);
        check("hold_data", bus.fb_data, pd);
      end
      if (bus.fb_we && !bus.fb_busy) begin
        if (sb.size() == 0) begin
          tests_run++;
          failed++;
          $display("FAIL unexpected_write: addr %0d data 0x%0h with nothing outstanding",
                   bus.fb_addr, bus.fb_data);
        end else begin
          e = sb.pop_front();
          check("wr_addr", bus.fb_addr, e.addr);
          check("wr_data", bus.fb_data, e.data);
        end
        writes++;
      end
      stall = bus.fb_we && bus.fb_busy;
      pa    = bus.fb_addr;
      pd    = bus.fb_data;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_plot(input int x, input int y, input logic [11:0] c, input bit bg,
                            output bit acc);
    bit  rdy;
    int  a;
    wr_t w;
    bus.plot = 1'b1;
    bus.x    = 9'(x);
    bus.y    = 8'(y);
    bus.c    = c;
    bus.bg   = bg;
    @(negedge clk);
    rdy = bus.plot_ready;
    @(posedge clk);
    if (!rdy) ovf_exp = 1'b1;
    acc = rdy && (x < 320) && (y < 240);
    if (acc) begin
      a      = y * 320 + x;
      w.addr = 17'(a);
      w.data = bg ? rom_fn(a) : c;
      sb.push_back(w);
    end
    #1;
    bus.plot = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || !bus.idle) && n < 2000) begin
      tick();
      n++;
    end
    check({name, "_drained"}, (n < 2000), 1);
  endtask

  task automatic measure_latency(input string name, input int exp);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.fb_we && n < 20);
    check(name, n, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int acc_n;
    int first_refused;
    int w0;
    int x;
    int y;

    reset    = 1'b1;
    bus.plot = 1'b0;
    bus.x    = '0;
    bus.y    = '0;
    bus.c    = '0;
    bus.bg   = 1'b0;
    tick(3);

    check("rst_fb_we", bus.fb_we, 0);
    check("rst_fb_addr", bus.fb_addr, 0);
    check("rst_fb_data", bus.fb_data, 0);
    check("rst_rom_addr", bus.rom_addr, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_plot_ready", bus.plot_ready, 1);
    check("rst_idle", bus.idle, 1);
    reset = 1'b0;
    tick();

    // Single colour pixel: two-cycle latency, address 2*320+10.
    drive_plot(10, 2, 12'hF00, 1'b0, acc);
    measure_latency("lat_colour", 2);
    check("t1_addr", bus.fb_addr, 650);
    check("t1_data", bus.fb_data, 12'hF00);
    tick(3);
    check("t1_idle", bus.idle, 1);

    // Background pixel at the last screen address.
    drive_plot(319, 239, 12'h123, 1'b1, acc);
    measure_latency("lat_bg", 3 + ROM_LAT);
    check("t2_addr", bus.fb_addr, 76799);
    check("t2_data", bus.fb_data, 12'h0A5);
    wait_drain("t2");

    // Off-screen requests are dropped without flagging overflow.
    w0 = writes;
    drive_plot(320, 0, 12'hABC, 1'b0, acc);
    drive_plot(0, 240, 12'hABC, 1'b0, acc);
    tick(6);
    check("t4_no_write", writes - w0, 0);
    check("t4_overflow", bus.overflow, 0);
    check("t4_idle", bus.idle, 1);

    // Stalled burst: DEPTH entries queue up plus one already popped into the write register.
    busy_force    = 1'b1;
    tick();
    acc_n         = 0;
    first_refused = -1;
    for (int i = 0; i < 10; i++) begin
      drive_plot($urandom_range(0, 319), $urandom_range(0, 239), 12'($urandom),
                 ($urandom_range(0, 1) == 1), acc);
      if (acc) acc_n++;
      else if (first_refused < 0) first_refused = i;
    end
    check("t3_accepted", acc_n, DEPTH + 1);
    check("t3_first_refused", first_refused, DEPTH + 1);
    check("t3_plot_ready", bus.plot_ready, 0);
    check("t3_overflow", bus.overflow, ovf_exp);
    w0         = writes;
    busy_force = 1'b0;
    wait_drain("t3");
    check("t3_writes", writes - w0, DEPTH + 1);

    // Randomly toggling stall with a mixed burst.
    busy_rand = 1'b1;
    w0        = writes;
    acc_n     = 0;
    for (int i = 0; i < 12; i++) begin
      drive_plot($urandom_range(0, 319), $urandom_range(0, 239), 12'($urandom),
                 ($urandom_range(0, 2) == 0), acc);
      if (acc) acc_n++;
    end
    wait_drain("t5");
    check("t5_writes", writes - w0, acc_n);

    // Long random run with gaps and occasional off-screen coordinates.
    for (int i = 0; i < 80; i++) begin
      x = ($urandom_range(0, 9) == 0) ? $urandom_range(300, 340) : $urandom_range(0, 319);
      y = ($urandom_range(0, 9) == 0) ? $urandom_range(230, 250) : $urandom_range(0, 239);
      drive_plot(x, y, 12'($urandom), ($urandom_range(0, 3) == 0), acc);
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 4));
    end
    wait_drain("rand");
    busy_rand = 1'b0;
    tick();
    check("rand_overflow", bus.overflow, ovf_exp);

    // Reset while fetching from the ROM with three requests queued behind it.
    drive_plot(5, 5, 12'h111, 1'b1, acc);
    drive_plot(6, 5, 12'h222, 1'b0, acc);
    drive_plot(7, 5, 12'h333, 1'b1, acc);
    drive_plot(8, 5, 12'h444, 1'b0, acc);
    reset = 1'b1;
    sb.delete();
    ovf_exp = 1'b0;
    w0 = writes;
    tick();
    check("t6_fb_we", bus.fb_we, 0);
    check("t6_idle", bus.idle, 1);
    check("t6_overflow", bus.overflow, 0);
    check("t6_plot_ready", bus.plot_ready, 1);
    reset = 1'b0;
    tick(10);
    check("t6_no_stale_write", writes - w0, 0);

    // Normal operation resumes after the mid-drain reset.
    drive_plot(100, 50, 12'h5C3, 1'b0, acc);
    wait_drain("post_rst");
    check("post_rst_writes", writes - w0, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
